// File: rtl/fp8_pkg.sv
// Shared FP8 export definitions: format codes, per-format constants and the
// stage-1 to stage-2 payload carried by the fp8_pack pipeline.
package fp8_pkg;

    typedef enum logic {
        FMT_E5M2 = 1'b0,
        FMT_E4M3 = 1'b1
    } fmt_e;

    typedef enum logic [1:0] {
        CLS_FIN  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    localparam int unsigned FP16_EW   = 5;
    localparam int unsigned FP16_MW   = 10;
    localparam int unsigned FP16_BIAS = 15;

    localparam int unsigned E5M2_BIAS = 15;
    localparam int unsigned E5M2_MW   = 2;
    localparam int unsigned E4M3_BIAS = 7;
    localparam int unsigned E4M3_MW   = 3;

    localparam logic [6:0] E5M2_MAX_MAG = 7'h7B;
    localparam logic [6:0] E5M2_INF_MAG = 7'h7C;
    localparam logic [6:0] E4M3_MAX_MAG = 7'h7E;
    localparam logic [7:0] NAN_CODE     = 8'h7F;

    typedef struct packed {
        logic                 sign;
        logic [FP16_EW-1:0]   exp;
        logic [FP16_MW-1:0]   man;
    } fp16_t;

    // Aligned value awaiting rounding. sig holds integer bit plus mantissa,
    // right-justified: E4M3 uses [3:0], E5M2 uses [2:0] with sig[3]=0.
    typedef struct packed {
        logic        sign;
        fmt_e        fmt;
        cls_e        cls;
        logic [6:0]  exp;
        logic [3:0]  sig;
        logic        g;
        logic        r;
        logic        s;
    } s1_t;

    function automatic fp16_t fp16_fields(input logic [15:0] x);
        fp16_t f;
        f.sign = x[15];
        f.exp  = x[14:10];
        f.man  = x[9:0];
        return f;
    endfunction

endpackage

// File: rtl/fp8_round_pack.sv
// Combinational RNE rounding, overflow handling and FP8 packing of an
// aligned value; also resolves NaN/Inf/zero classes.
module fp8_round_pack #(
    parameter bit         SATURATE = 1'b1,
    parameter logic [7:0] NAN_CODE = fp8_pkg::NAN_CODE
) (
    input  fp8_pkg::s1_t i_s1,
    output logic [7:0]   o_data_c,
    output logic         o_nv_c,
    output logic         o_of_c,
    output logic         o_uf_c,
    output logic         o_nx_c
);
    import fp8_pkg::*;

    logic       w_inc;
    logic [4:0] w_sum;
    logic       w_carry;
    logic       w_norm;
    logic       w_tiny;
    logic       w_inexact;
    logic [2:0] w_mant;
    logic [6:0] w_exp_r;
    logic       w_ovf;
    logic [6:0] w_max_mag;

    always_comb begin
        w_inc     = 1'b0;
        w_sum     = 5'd0;
        w_carry   = 1'b0;
        w_norm    = 1'b0;
        w_tiny    = 1'b0;
        w_mant    = 3'd0;
        w_exp_r   = 7'd0;
        w_ovf     = 1'b0;
        w_inexact = i_s1.g | i_s1.r | i_s1.s;
        w_max_mag = (i_s1.fmt == FMT_E4M3) ? E4M3_MAX_MAG : E5M2_MAX_MAG;
        o_data_c  = 8'h00;
        o_nv_c    = 1'b0;
        o_of_c    = 1'b0;
        o_uf_c    = 1'b0;
        o_nx_c    = 1'b0;

        // Round to nearest even; sig[0] is the mantissa LSB in both layouts.
        w_inc = i_s1.g & (i_s1.r | i_s1.s | i_s1.sig[0]);
        w_sum = {1'b0, i_s1.sig} + 5'(w_inc);
        if (i_s1.fmt == FMT_E4M3) begin
            w_carry = w_sum[4];
            w_norm  = w_sum[3] | w_sum[4];
            w_mant  = w_sum[2:0];
            w_tiny  = ~i_s1.sig[3];
        end else begin
            w_carry = w_sum[3];
            w_norm  = w_sum[2] | w_sum[3];
            w_mant  = {1'b0, w_sum[1:0]};
            w_tiny  = ~i_s1.sig[2];
        end
        w_exp_r = i_s1.exp + 7'(w_carry);

        // E4M3 has no infinity and 1.111 x 2^8 encodes NaN.
        if (i_s1.fmt == FMT_E4M3) begin
            w_ovf = ($signed(w_exp_r) > 7'sd8) ||
                    (($signed(w_exp_r) == 7'sd8) && (w_mant == 3'b111));
        end else begin
            w_ovf = $signed(w_exp_r) > 7'sd15;
        end

        case (i_s1.cls)
            CLS_NAN: begin
                o_data_c = NAN_CODE;
                o_nv_c   = 1'b1;
            end
            CLS_INF: begin
                if (i_s1.fmt == FMT_E5M2) begin
                    o_data_c = {i_s1.sign, E5M2_INF_MAG};
                end else begin
                    o_data_c = SATURATE ? {i_s1.sign, E4M3_MAX_MAG} : NAN_CODE;
                    o_of_c   = 1'b1;
                end
            end
            CLS_ZERO: begin
                o_data_c = {i_s1.sign, 7'h00};
            end
            default: begin
                if (w_ovf) begin
                    o_of_c = 1'b1;
                    o_nx_c = 1'b1;
                    if (SATURATE)
                        o_data_c = {i_s1.sign, w_max_mag};
                    else if (i_s1.fmt == FMT_E5M2)
                        o_data_c = {i_s1.sign, E5M2_INF_MAG};
                    else
                        o_data_c = NAN_CODE;
                end else begin
                    o_nx_c = w_inexact;
                    o_uf_c = w_tiny & w_inexact;
                    if (i_s1.fmt == FMT_E4M3)
                        o_data_c = {i_s1.sign,
                                    w_norm ? 4'(w_exp_r + 7'(E4M3_BIAS)) : 4'd0,
                                    w_mant};
                    else
                        o_data_c = {i_s1.sign,
                                    w_norm ? 5'(w_exp_r + 7'(E5M2_BIAS)) : 5'd0,
                                    w_mant[1:0]};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp8_pack.sv
// FP16 -> FP8 (E5M2/E4M3) return-path encoder: two-stage valid/ready pipeline
// with sticky exception flags.
module fp8_pack #(
    parameter bit         SATURATE = 1'b1,
    parameter logic [7:0] NAN_CODE = fp8_pkg::NAN_CODE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_fmt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    input  logic        flag_clr,
    output logic        flag_nv,
    output logic        flag_of,
    output logic        flag_uf,
    output logic        flag_nx
);
    import fp8_pkg::*;

    logic        r_s1_valid;
    s1_t         r_s1;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic [3:0]  r_s2_flags;
    logic [3:0]  r_flags;

    logic        w_adv1;
    logic        w_adv2;
    logic        w_out_hs;
    fp16_t       w_f;
    fmt_e        w_fmt;
    logic [10:0] w_sig11;
    logic signed [6:0] w_e;
    logic signed [6:0] w_emin;
    logic signed [6:0] w_sh;
    logic [21:0] w_wide;
    logic [10:0] w_al;
    logic        w_low;
    s1_t         w_s1;
    logic [7:0]  w_pk_data;
    logic        w_pk_nv;
    logic        w_pk_of;
    logic        w_pk_uf;
    logic        w_pk_nx;

    assign w_adv2   = !r_out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign w_out_hs = r_out_valid && out_ready;
    assign in_ready = w_adv1;

    // Stage 1: classify, align into the target range, form guard/round/sticky.
    always_comb begin
        w_f     = fp16_fields(in_data);
        w_fmt   = fmt_e'(in_fmt);
        w_sig11 = {(w_f.exp != 5'd0), w_f.man};
        w_e     = (w_f.exp == 5'd0) ? -7'sd14
                                    : $signed({2'b00, w_f.exp}) - 7'sd15;
        w_emin  = (w_fmt == FMT_E4M3) ? -7'sd6 : -7'sd14;
        w_sh    = w_emin - w_e;
        w_wide  = {w_sig11, 11'd0};
        if (w_sh >= 7'sd12)
            w_wide = {21'd0, |w_sig11};
        else if (w_sh > 7'sd0)
            w_wide = {w_sig11, 11'd0} >> w_sh[3:0];
        w_al  = w_wide[21:11];
        w_low = |w_wide[10:0];

        w_s1      = '0;
        w_s1.sign = w_f.sign;
        w_s1.fmt  = w_fmt;
        w_s1.exp  = 7'((w_sh > 7'sd0) ? w_emin : w_e);
        if (w_fmt == FMT_E4M3) begin
            w_s1.sig = w_al[10:7];
            w_s1.g   = w_al[6];
            w_s1.r   = w_al[5];
            w_s1.s   = (|w_al[4:0]) | w_low;
        end else begin
            w_s1.sig = {1'b0, w_al[10:8]};
            w_s1.g   = w_al[7];
            w_s1.r   = w_al[6];
            w_s1.s   = (|w_al[5:0]) | w_low;
        end
        if (w_f.exp == 5'h1F)
            w_s1.cls = (w_f.man != 10'd0) ? CLS_NAN : CLS_INF;
        else if ((w_f.exp == 5'd0) && (w_f.man == 10'd0))
            w_s1.cls = CLS_ZERO;
        else
            w_s1.cls = CLS_FIN;
    end

    fp8_round_pack #(
        .SATURATE (SATURATE),
        .NAN_CODE (NAN_CODE)
    ) u_round_pack (
        .i_s1     (r_s1),
        .o_data_c (w_pk_data),
        .o_nv_c   (w_pk_nv),
        .o_of_c   (w_pk_of),
        .o_uf_c   (w_pk_uf),
        .o_nx_c   (w_pk_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_s2_flags  <= 4'd0;
            r_flags     <= 4'd0;
        end else begin
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid)
                    r_s1 <= w_s1;
            end
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_pk_data;
                    r_s2_flags <= {w_pk_nv, w_pk_of, w_pk_uf, w_pk_nx};
                end
            end
            // A clear in the same cycle as a handshake keeps that result's events.
            if (flag_clr)
                r_flags <= w_out_hs ? r_s2_flags : 4'd0;
            else if (w_out_hs)
                r_flags <= r_flags | r_s2_flags;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign flag_nv   = r_flags[3];
    assign flag_of   = r_flags[2];
    assign flag_uf   = r_flags[1];
    assign flag_nx   = r_flags[0];

endmodule

// File: tb/tb_fp8_pack.sv
// Scoreboard bench for fp8_pack: a saturating and a non-saturating instance
// share stimulus; expected bytes for both and flag events are queued per input.
module tb_fp8_pack;

    typedef struct packed {
        logic [7:0] d_sat;
        logic [7:0] d_wrap;
        logic [3:0] fl;     // {nv, of, uf, nx}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_fmt = 1'b0;
    logic        out_ready = 1'b1;
    logic        flag_clr = 1'b0;

    logic        in_ready_s, out_valid_s, nv_s, of_s, uf_s, nx_s;
    logic [7:0]  out_data_s;
    logic        in_ready_w, out_valid_w, nv_w, of_w, uf_w, nx_w;
    logic [7:0]  out_data_w;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp8_pack #(.SATURATE(1'b1), .NAN_CODE(8'h7F)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_fmt(in_fmt), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .flag_clr(flag_clr),
        .flag_nv(nv_s), .flag_of(of_s), .flag_uf(uf_s), .flag_nx(nx_s)
    );

    fp8_pack #(.SATURATE(1'b0), .NAN_CODE(8'h7F)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .in_fmt(in_fmt), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .flag_clr(flag_clr),
        .flag_nv(nv_w), .flag_of(of_w), .flag_uf(uf_w), .flag_nx(nx_w)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Present one value and push its expectation on the accepting edge.
    task automatic send(input logic [15:0] d, input logic f, input exp_t e);
        bit hs;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_fmt   = f;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            hs = in_ready_s;
            @(posedge clk);
            if (hs) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!done) timeout_fail("send");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (sb_q.size() == 0 && !out_valid_s) ok = 1'b1;
            else @(posedge clk);
        end
        #1;
        if (!ok) timeout_fail("drain");
    endtask

    task automatic clear_flags();
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
    endtask

    // Monitor: pops on output handshakes, checks held data and the sticky flag model.
    initial begin
        logic [3:0] model;
        logic [3:0] ev;
        bit         hs;
        exp_t       e;
        model = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model = 4'd0;
            end else begin
                chk("flags_sat",  16'({nv_s, of_s, uf_s, nx_s}), 16'(model));
                chk("flags_wrap", 16'({nv_w, of_w, uf_w, nx_w}), 16'(model));
                if (out_valid_s && !out_ready && sb_q.size() > 0) begin
                    chk("hold_sat",  16'(out_data_s), 16'(sb_q[0].d_sat));
                    chk("hold_wrap", 16'(out_data_w), 16'(sb_q[0].d_wrap));
                end
                hs = out_valid_s && out_ready;
                ev = 4'd0;
                if (hs) begin
                    if (sb_q.size() == 0) begin
                        timeout_fail("unexpected_output");
                    end else begin
                        e = sb_q.pop_front();
                        chk("data_sat",  16'(out_data_s), 16'(e.d_sat));
                        chk("data_wrap", 16'(out_data_w), 16'(e.d_wrap));
                        chk("valid_wrap", 16'(out_valid_w), 16'd1);
                        ev = e.fl;
                    end
                end
                if (flag_clr) model = hs ? ev : 4'd0;
                else if (hs)  model = model | ev;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready",  16'(in_ready_s), 16'd1);
        chk("rst_out_valid", 16'(out_valid_s), 16'd0);
        chk("rst_out_data",  16'(out_data_s), 16'h00);
        chk("rst_flags",     16'({nv_s, of_s, uf_s, nx_s}), 16'd0);

        // 1.0 to both formats back to back; first result two cycles after input.
        send(16'h3C00, 1'b1, '{8'h38, 8'h38, 4'b0000});
        send(16'h3C00, 1'b0, '{8'h3C, 8'h3C, 4'b0000});
        chk("latency_first",  16'({out_valid_s, out_data_s}), 16'h138);
        @(posedge clk);
        #1;
        chk("latency_second", 16'({out_valid_s, out_data_s}), 16'h13C);
        drain();

        // E5M2 ties to even.
        send(16'h3C80, 1'b0, '{8'h3C, 8'h3C, 4'b0001});
        send(16'h3D80, 1'b0, '{8'h3E, 8'h3E, 4'b0001});
        drain();
        chk("tie_nx_uf", 16'({uf_s, nx_s}), 16'b01);
        clear_flags();

        // E4M3 top of range and subnormal boundary.
        send(16'h5F00, 1'b1, '{8'h7E, 8'h7E, 4'b0000});
        send(16'h5F80, 1'b1, '{8'h7E, 8'h7F, 4'b0101});
        send(16'h1800, 1'b1, '{8'h01, 8'h01, 4'b0000});
        send(16'h1400, 1'b1, '{8'h00, 8'h00, 4'b0011});

        // Specials and misc.
        send(16'h7BFF, 1'b0, '{8'h7B, 8'h7C, 4'b0101});
        send(16'hFC00, 1'b1, '{8'hFE, 8'h7F, 4'b0100});
        send(16'h7E00, 1'b0, '{8'h7F, 8'h7F, 4'b1000});
        send(16'h8000, 1'b0, '{8'h80, 8'h80, 4'b0000});
        send(16'h0200, 1'b0, '{8'h02, 8'h02, 4'b0000});
        send(16'hC000, 1'b1, '{8'hC0, 8'hC0, 4'b0000});
        drain();
        chk("flags_all", 16'({nv_s, of_s, uf_s, nx_s}), 16'b1111);
        clear_flags();

        // Backpressure: output stalls three cycles while four values stream in.
        out_ready = 1'b0;
        fork
            begin
                send(16'h3C00, 1'b1, '{8'h38, 8'h38, 4'b0000});
                send(16'h4000, 1'b1, '{8'h40, 8'h40, 4'b0000});
                send(16'h4200, 1'b1, '{8'h44, 8'h44, 4'b0000});
                send(16'h3C00, 1'b0, '{8'h3C, 8'h3C, 4'b0000});
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_in_ready", 16'(in_ready_s), 16'd0);
                chk("bp_out_data", 16'({out_valid_s, out_data_s}), 16'h138);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while two results are in flight: both discarded, flags cleared.
        send(16'h3C80, 1'b0, '{8'h3C, 8'h3C, 4'b0001});
        drain();
        send(16'h4000, 1'b1, '{8'h40, 8'h40, 4'b0000});
        send(16'h4200, 1'b1, '{8'h44, 8'h44, 4'b0000});
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_rst_valid", 16'(out_valid_s), 16'd0);
        chk("mid_rst_flags", 16'({nv_s, of_s, uf_s, nx_s}), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 16'(out_valid_s), 16'd0);

        // Clear coinciding with an overflowing output handshake.
        send(16'h5F80, 1'b1, '{8'h7E, 8'h7F, 4'b0101});
        @(posedge clk);
        #1;
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("clr_set_wins", 16'({of_s, nx_s}), 16'b11);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
